// File: rtl/bcd_count_sequencer_if.sv
// Request/command and display/status bundle for the BCD count sequencer.
interface bcd_count_sequencer_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   up_req;
  logic [DIGITS-1:0]   dn_req;
  logic                set9;
  logic                set0;
  logic [4*DIGITS-1:0] digits;
  logic                busy;
  logic                ovf;
  logic                unf;
  logic                drop;

  modport master (
    output up_req, dn_req, set9, set0,
    input  digits, busy, ovf, unf, drop
  );

  modport slave (
    input  up_req, dn_req, set9, set0,
    output digits, busy, ovf, unf, drop
  );
endinterface

// File: rtl/bcd_count_sequencer.sv
// Serialized BCD counter: per-digit up/down requests are queued as pending bits,
// granted lowest-digit-first, and carry/borrow ripples one digit per clock.
module bcd_count_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_count_sequencer_if.slave bus
);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

  typedef enum logic [0:0] {IDLE, STEP} state_t;

  state_t            state_reg;
  logic [IDXW-1:0]   cur_reg;
  logic              dir_up_reg;
  logic [DIGITS-1:0] pend_up_reg, pend_dn_reg;
  logic [DIGITS-1:0] pend_up_next, pend_dn_next;
  logic [3:0]        digit_reg [DIGITS];
  logic              ovf_reg, unf_reg, drop_reg;

  logic              set_any;
  logic              grant_found, grant_up, grant_en;
  logic [IDXW-1:0]   grant_idx;
  logic [DIGITS-1:0] grant_up_vec, grant_dn_vec, drop_vec;
  logic [4*DIGITS-1:0] digits_flat;
  logic [3:0]        cur_digit;

  assign set_any = bus.set0 | bus.set9;

  // Descending scan so the lowest pending digit wins; up beats dn at one index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_up    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (pend_up_reg[i] | pend_dn_reg[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDXW'(i);
        grant_up    = pend_up_reg[i];
      end
    end
  end

  assign grant_en  = (state_reg == IDLE) & grant_found & ~set_any;
  assign cur_digit = digit_reg[cur_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign grant_up_vec[gi] = grant_en &  grant_up & (grant_idx == IDXW'(gi));
      assign grant_dn_vec[gi] = grant_en & ~grant_up & (grant_idx == IDXW'(gi));
      // A request hitting an already-pending bit is lost, even if that bit is granted now.
      assign pend_up_next[gi] = set_any ? 1'b0 :
                                (pend_up_reg[gi] ? ~grant_up_vec[gi] : bus.up_req[gi]);
      assign pend_dn_next[gi] = set_any ? 1'b0 :
                                (pend_dn_reg[gi] ? ~grant_dn_vec[gi] : bus.dn_req[gi]);
      assign drop_vec[gi] = set_any ? (bus.up_req[gi] | bus.dn_req[gi]) :
                            ((bus.up_req[gi] & pend_up_reg[gi]) |
                             (bus.dn_req[gi] & pend_dn_reg[gi]));
      assign digits_flat[4*gi +: 4] = digit_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cur_reg     <= '0;
      dir_up_reg  <= 1'b0;
      pend_up_reg <= '0;
      pend_dn_reg <= '0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
      drop_reg    <= 1'b0;
      for (int i = 0; i < DIGITS; i++) digit_reg[i] <= 4'd0;
    end else begin
      pend_up_reg <= pend_up_next;
      pend_dn_reg <= pend_dn_next;
      drop_reg    <= |drop_vec;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
      if (set_any) begin
        state_reg <= IDLE;
        for (int i = 0; i < DIGITS; i++) digit_reg[i] <= bus.set0 ? 4'd0 : 4'd9;
      end else begin
        case (state_reg)
          IDLE: begin
            if (grant_found) begin
              cur_reg    <= grant_idx;
              dir_up_reg <= grant_up;
              state_reg  <= STEP;
            end
          end
          STEP: begin
            if (dir_up_reg) begin
              if (cur_digit != 4'd9) begin
                digit_reg[cur_reg] <= cur_digit + 4'd1;
                state_reg          <= IDLE;
              end else begin
                digit_reg[cur_reg] <= 4'd0;
                if (cur_reg != LAST) begin
                  cur_reg <= cur_reg + IDXW'(1);
                end else begin
                  ovf_reg   <= 1'b1;
                  state_reg <= IDLE;
                end
              end
            end else begin
              if (cur_digit != 4'd0) begin
                digit_reg[cur_reg] <= cur_digit - 4'd1;
                state_reg          <= IDLE;
              end else begin
                digit_reg[cur_reg] <= 4'd9;
                if (cur_reg != LAST) begin
                  cur_reg <= cur_reg + IDXW'(1);
                end else begin
                  unf_reg   <= 1'b1;
                  state_reg <= IDLE;
                end
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.digits = digits_flat;
  assign bus.busy   = (state_reg != IDLE) | (|pend_up_reg) | (|pend_dn_reg);
  assign bus.ovf    = ovf_reg;
  assign bus.unf    = unf_reg;
  assign bus.drop   = drop_reg;
endmodule
